// File: rtl/regfile_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_scoreboard: register busy scoreboard + round-robin 2:1 writeback arbiter  (rev 1.0)
// ----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_wr_rd,
  output logic            issue_ready,
  input  logic            wb_alu_valid,
  input  logic            wb_mem_valid,
  input  logic [4:0]      wb_alu_rd,
  input  logic [4:0]      wb_mem_rd,
  input  logic [XLEN-1:0] wb_alu_data,
  input  logic [XLEN-1:0] wb_mem_data,
  output logic            wb_alu_ready,
  output logic            wb_mem_ready,
  output logic            rf_RegWrite,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_WriteData,
  output logic [NREG-1:0] busy_vec,
  output logic            err_spurious_wb
);

  localparam logic c_GRANT_ALU = 1'b0;
  localparam logic c_GRANT_MEM = 1'b1;

  logic [NREG-1:0] busy_q, busy_d;
  logic            last_grant_q, last_grant_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;

  logic            w_hazard;
  logic            w_issue_fire;
  logic            w_grant_alu;
  logic            w_grant_mem;
  logic [4:0]      w_win_rd;
  logic [XLEN-1:0] w_win_data;

  always_comb begin
    w_hazard = (issue_use_rs1 && busy_q[issue_rs1] && (issue_rs1 != 5'd0)) ||
               (issue_use_rs2 && busy_q[issue_rs2] && (issue_rs2 != 5'd0)) ||
               (issue_wr_rd   && busy_q[issue_rd]  && (issue_rd  != 5'd0));
  end

  assign issue_ready  = ~w_hazard;
  assign w_issue_fire = issue_valid && issue_ready;

  // MEM wins a tie only when ALU had the previous grant.
  assign w_grant_mem = wb_mem_valid && (!wb_alu_valid || (last_grant_q == c_GRANT_ALU));
  assign w_grant_alu = wb_alu_valid && !w_grant_mem;
  assign w_win_rd    = w_grant_mem ? wb_mem_rd   : wb_alu_rd;
  assign w_win_data  = w_grant_mem ? wb_mem_data : wb_alu_data;

  always_comb begin
    busy_d       = busy_q;
    regwrite_d   = 1'b0;
    rd_d         = rd_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;

    // Clear lands with the register-file commit; a same-index issue set overrides it.
    if (regwrite_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (w_issue_fire && issue_wr_rd && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (w_grant_alu || w_grant_mem) begin
      regwrite_d   = (w_win_rd != 5'd0);
      rd_d         = w_win_rd;
      wdata_d      = w_win_data;
      last_grant_d = w_grant_mem ? c_GRANT_MEM : c_GRANT_ALU;
      if ((w_win_rd != 5'd0) && !busy_q[w_win_rd]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= '0;
      last_grant_q <= c_GRANT_ALU;
      regwrite_q   <= 1'b0;
      rd_q         <= 5'd0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      regwrite_q   <= regwrite_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

  assign wb_alu_ready    = w_grant_alu;
  assign wb_mem_ready    = w_grant_mem;
  assign rf_RegWrite     = regwrite_q;
  assign rf_rd           = rd_q;
  assign rf_WriteData    = wdata_q;
  assign busy_vec        = busy_q;
  assign err_spurious_wb = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_scoreboard: directed checks of hazards, arbitration, errors, reset  (rev 1.0)
// ----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [4:0]      issue_rs1, issue_rs2, issue_rd;
  logic            issue_use_rs1, issue_use_rs2, issue_wr_rd;
  logic            issue_ready;
  logic            wb_alu_valid, wb_mem_valid;
  logic [4:0]      wb_alu_rd, wb_mem_rd;
  logic [XLEN-1:0] wb_alu_data, wb_mem_data;
  logic            wb_alu_ready, wb_mem_ready;
  logic            rf_RegWrite;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_WriteData;
  logic [NREG-1:0] busy_vec;
  logic            err_spurious_wb;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_wr_rd(issue_wr_rd), .issue_ready(issue_ready),
    .wb_alu_valid(wb_alu_valid), .wb_mem_valid(wb_mem_valid),
    .wb_alu_rd(wb_alu_rd), .wb_mem_rd(wb_mem_rd),
    .wb_alu_data(wb_alu_data), .wb_mem_data(wb_mem_data),
    .wb_alu_ready(wb_alu_ready), .wb_mem_ready(wb_mem_ready),
    .rf_RegWrite(rf_RegWrite), .rf_rd(rf_rd), .rf_WriteData(rf_WriteData),
    .busy_vec(busy_vec), .err_spurious_wb(err_spurious_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_issue();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0;
  endtask

  task automatic idle_wb();
    wb_alu_valid = 0; wb_mem_valid = 0; wb_alu_rd = 0; wb_mem_rd = 0;
    wb_alu_data = 0; wb_mem_data = 0;
  endtask

  task automatic do_issue_wr(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd; issue_wr_rd = 1;
  endtask

  // An issue set and a pending busy clear must never hit the same register at one edge.
  always @(posedge clk) begin
    if (!reset && issue_valid && issue_ready && issue_wr_rd && (issue_rd != 0) &&
        rf_RegWrite && (rf_rd == issue_rd)) begin
      errors++;
      $error("FAIL set_clear_collision observed=%0d expected=none", issue_rd);
    end
  end

  initial begin
    reset = 1; idle_issue(); idle_wb();
    tick(); tick();
    chk("rst_busy", busy_vec, 0);
    chk("rst_regwrite", rf_RegWrite, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_WriteData, 0);
    chk("rst_err", err_spurious_wb, 0);
    chk("rst_ready", issue_ready, 1);
    reset = 0;

    // RAW: write r5, then a reader of r5 stalls until the commit edge
    do_issue_wr(5); #1;
    chk("raw_first_ready", issue_ready, 1);
    tick(); idle_issue();
    chk("raw_busy5", busy_vec, 64'h20);
    issue_valid = 1; issue_rs1 = 5; issue_use_rs1 = 1;
    wb_alu_valid = 1; wb_alu_rd = 5; wb_alu_data = 64'h55; #1;
    chk("raw_stall", issue_ready, 0);
    chk("raw_alu_ready", wb_alu_ready, 1);
    chk("raw_mem_ready", wb_mem_ready, 0);
    tick(); idle_wb(); #1;
    chk("raw_regwrite", rf_RegWrite, 1);
    chk("raw_rd", rf_rd, 5);
    chk("raw_data", rf_WriteData, 64'h55);
    chk("raw_still_stall", issue_ready, 0);
    tick();
    chk("raw_regwrite_off", rf_RegWrite, 0);
    chk("raw_busy_clear", busy_vec, 0);
    chk("raw_released", issue_ready, 1);
    chk("raw_no_err", err_spurious_wb, 0);
    idle_issue();

    // Tie after reset: MEM first, then ALU
    reset = 1; tick(); reset = 0;
    do_issue_wr(3); tick(); do_issue_wr(4); tick(); idle_issue();
    chk("tie_busy34", busy_vec, 64'h18);
    wb_alu_valid = 1; wb_alu_rd = 3; wb_alu_data = 64'hAA;
    wb_mem_valid = 1; wb_mem_rd = 4; wb_mem_data = 64'hBB; #1;
    chk("tie_mem_ready", wb_mem_ready, 1);
    chk("tie_alu_wait", wb_alu_ready, 0);
    tick();
    chk("tie1_rd", rf_rd, 4);
    chk("tie1_data", rf_WriteData, 64'hBB);
    chk("tie1_regwrite", rf_RegWrite, 1);
    wb_mem_valid = 0; #1;
    chk("tie_alu_now", wb_alu_ready, 1);
    tick(); idle_wb();
    chk("tie2_rd", rf_rd, 3);
    chk("tie2_data", rf_WriteData, 64'hAA);
    chk("tie2_busy", busy_vec, 64'h08);
    tick();
    chk("hold_regwrite", rf_RegWrite, 0);
    chk("hold_rd", rf_rd, 3);
    chk("hold_data", rf_WriteData, 64'hAA);
    chk("tie_busy_empty", busy_vec, 0);
    chk("tie_no_err", err_spurious_wb, 0);

    // Register 0: never busy, writeback dropped silently
    do_issue_wr(0); tick(); idle_issue();
    chk("r0_busy", busy_vec, 0);
    wb_alu_valid = 1; wb_alu_rd = 0; wb_alu_data = 64'h11; #1;
    chk("r0_alu_ready", wb_alu_ready, 1);
    tick(); idle_wb();
    chk("r0_regwrite", rf_RegWrite, 0);
    chk("r0_busy_after", busy_vec, 0);
    chk("r0_err", err_spurious_wb, 0);

    // Spurious writeback to idle r7
    wb_mem_valid = 1; wb_mem_rd = 7; wb_mem_data = 64'h77; #1;
    chk("sp_mem_ready", wb_mem_ready, 1);
    tick(); idle_wb();
    chk("sp_regwrite", rf_RegWrite, 1);
    chk("sp_rd", rf_rd, 7);
    chk("sp_err", err_spurious_wb, 1);
    tick(); tick();
    chk("sp_err_sticky", err_spurious_wb, 1);

    // Last grant was MEM, so ALU wins this tie
    wb_alu_valid = 1; wb_alu_rd = 1; wb_alu_data = 64'h01;
    wb_mem_valid = 1; wb_mem_rd = 2; wb_mem_data = 64'h02; #1;
    chk("rr_alu_ready", wb_alu_ready, 1);
    chk("rr_mem_wait", wb_mem_ready, 0);
    tick(); idle_wb();
    chk("rr_rd", rf_rd, 1);
    tick();

    // Reset with a grant in flight
    reset = 1; tick(); reset = 0;
    chk("rst2_err", err_spurious_wb, 0);
    do_issue_wr(9); tick(); idle_issue();
    chk("fl_busy9", busy_vec, 64'h200);
    wb_alu_valid = 1; wb_alu_rd = 9; wb_alu_data = 64'h99;
    tick(); idle_wb();
    chk("fl_regwrite", rf_RegWrite, 1);
    reset = 1; tick(); reset = 0;
    chk("fl_busy", busy_vec, 0);
    chk("fl_regwrite_off", rf_RegWrite, 0);
    chk("fl_ready", issue_ready, 1);
    tick();
    chk("fl_busy_stays", busy_vec, 0);

    // WAW on r12
    do_issue_wr(12); tick();
    chk("waw_busy", busy_vec, 64'h1000);
    chk("waw_stall", issue_ready, 0);
    tick();
    chk("waw_stall2", issue_ready, 0);
    wb_alu_valid = 1; wb_alu_rd = 12; wb_alu_data = 64'hC1;
    tick(); idle_wb();
    chk("waw_stall3", issue_ready, 0);
    tick();
    chk("waw_released", issue_ready, 1);
    chk("waw_busy_clear", busy_vec, 0);
    tick(); idle_issue();
    chk("waw_second_busy", busy_vec, 64'h1000);
    issue_valid = 1; issue_rs2 = 12; issue_use_rs2 = 1; #1;
    chk("rs2_stall", issue_ready, 0);
    idle_issue(); #1;
    chk("no_valid_ready", issue_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
